// File: rtl/mode_sequencer_if.sv
// Front-panel bus between the mode sequencer and its user/datapath side.
// The master drives buttons, digits and buzzer levels. The slave (the sequencer) drives mode, strobes and the edit path.
interface mode_sequencer_if;
  logic       mode_btn;
  logic       edit_strobe;
  logic [3:0] loadin;
  logic       buzz_alm;
  logic       buzz_tmr;
  logic       ack;
  logic [2:0] mode;
  logic       load;
  logic       almin;
  logic       tmrin;
  logic       sw;
  logic       tmr;
  logic [2:0] select;
  logic       field_wr;
  logic [3:0] field_data;
  logic       digit_err;
  logic       alert;
  logic       alert_src;

  modport master (
    output mode_btn, edit_strobe, loadin, buzz_alm, buzz_tmr, ack,
    input  mode, load, almin, tmrin, sw, tmr, select, field_wr, field_data,
           digit_err, alert, alert_src
  );

  modport slave (
    input  mode_btn, edit_strobe, loadin, buzz_alm, buzz_tmr, ack,
    output mode, load, almin, tmrin, sw, tmr, select, field_wr, field_data,
           digit_err, alert, alert_src
  );
endinterface

// File: rtl/mode_sequencer.sv
// Front-panel mode sequencer for the digital clock.
// It owns the digit edit path and the cursor, and it arbitrates alarm and timer buzzer events into one alert state.
module mode_sequencer #(
  parameter int IDLE_TIMEOUT = 30,
  parameter int ALERT_HOLD   = 60,
  parameter int CNT_W        = 7
) (
  input  logic            clk_out,
  input  logic            swrst,
  mode_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    CLOCK     = 3'd0,
    SET_CLK   = 3'd1,
    SET_ALM   = 3'd2,
    SET_TMR   = 3'd3,
    STOPWATCH = 3'd4,
    TIMER_RUN = 3'd5,
    ALERT     = 3'd6
  } mode_e;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ALERT_HOLD - 1);

  // Strobe vector ordering: {load, almin, tmrin, sw, tmr}
  function automatic logic [4:0] strobes_of(input mode_e m);
    case (m)
      SET_CLK:   return 5'b10000;
      SET_ALM:   return 5'b01000;
      SET_TMR:   return 5'b00100;
      STOPWATCH: return 5'b00010;
      TIMER_RUN: return 5'b00001;
      default:   return 5'b00000;
    endcase
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      CLOCK:     return SET_CLK;
      SET_CLK:   return SET_ALM;
      SET_ALM:   return SET_TMR;
      SET_TMR:   return STOPWATCH;
      STOPWATCH: return TIMER_RUN;
      default:   return CLOCK;
    endcase
  endfunction

  function automatic logic is_set(input mode_e m);
    return (m == SET_CLK) || (m == SET_ALM) || (m == SET_TMR);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // The alarm has no seconds fields, so its cursor stops at field 2.
  function automatic logic [2:0] cursor_dec(input logic [2:0] s, input mode_e m);
    logic [2:0] lo;
    lo = (m == SET_ALM) ? 3'd2 : 3'd0;
    return (s <= lo) ? 3'd5 : s - 3'd1;
  endfunction

  function automatic logic digit_ok(input logic [2:0] s, input logic [3:0] d,
                                    input logic h1_is_two);
    case (s)
      3'd1, 3'd3: return d <= 4'd5;
      3'd4:       return h1_is_two ? (d <= 4'd3) : (d <= 4'd9);
      3'd5:       return d <= 4'd2;
      default:    return d <= 4'd9;
    endcase
  endfunction

  mode_e            mode_q;
  mode_e            saved_q;
  logic [4:0]       strb_q;
  logic [2:0]       select_q;
  logic             dec_pend_q;
  logic             field_wr_q;
  logic [3:0]       field_data_q;
  logic             digit_err_q;
  logic             alert_q;
  logic             alert_src_q;
  logic [CNT_W-1:0] idle_q;
  logic [CNT_W-1:0] hold_q;
  logic             pend_alm_q;
  logic             pend_tmr_q;
  logic             h1_clk_q;
  logic             h1_alm_q;
  logic             h1_tmr_q;
  logic             arm_q;
  logic             btn_q;
  logic             alm_q;
  logic             tmr_q;

  // Edge detectors stay disarmed for the first tick after reset.
  // A level that is already high when reset releases is not counted as an edge.
  always_ff @(posedge clk_out or posedge swrst) begin
    if (swrst) begin
      arm_q <= 1'b0;
      btn_q <= 1'b0;
      alm_q <= 1'b0;
      tmr_q <= 1'b0;
    end else begin
      arm_q <= 1'b1;
      btn_q <= bus.mode_btn;
      alm_q <= bus.buzz_alm;
      tmr_q <= bus.buzz_tmr;
    end
  end

  logic             btn_rise;
  logic             alm_rise;
  logic             tmr_rise;
  logic             take_alm;
  logic             take_tmr;
  logic             cur_h1_hi;
  logic             edit_ok;
  logic [2:0]       cur_sel;
  logic [CNT_W-1:0] idle_d;
  logic [CNT_W-1:0] hold_d;
  mode_e            nm;

  assign btn_rise  = arm_q & bus.mode_btn & ~btn_q;
  assign alm_rise  = arm_q & bus.buzz_alm & ~alm_q;
  assign tmr_rise  = arm_q & bus.buzz_tmr & ~tmr_q;
  assign take_alm  = alm_rise | pend_alm_q;
  assign take_tmr  = tmr_rise | pend_tmr_q;
  assign nm        = next_mode(mode_q);
  assign idle_d    = sat_inc(idle_q);
  assign hold_d    = sat_inc(hold_q);
  assign cur_h1_hi = (mode_q == SET_ALM) ? h1_alm_q :
                     (mode_q == SET_TMR) ? h1_tmr_q : h1_clk_q;

  // After a write, the cursor still shows the written field for one tick.
  // A strobe in that tick is judged against the field the cursor moves to next.
  assign cur_sel = dec_pend_q ? cursor_dec(select_q, mode_q) : select_q;
  assign edit_ok = digit_ok(cur_sel, bus.loadin, cur_h1_hi);

  always_ff @(posedge clk_out or posedge swrst) begin
    if (swrst) begin
      mode_q       <= CLOCK;
      saved_q      <= CLOCK;
      strb_q       <= '0;
      select_q     <= 3'd5;
      dec_pend_q   <= 1'b0;
      field_wr_q   <= 1'b0;
      field_data_q <= '0;
      digit_err_q  <= 1'b0;
      alert_q      <= 1'b0;
      alert_src_q  <= 1'b0;
      idle_q       <= '0;
      hold_q       <= '0;
      pend_alm_q   <= 1'b0;
      pend_tmr_q   <= 1'b0;
      h1_clk_q     <= 1'b0;
      h1_alm_q     <= 1'b0;
      h1_tmr_q     <= 1'b0;
    end else begin
      field_wr_q  <= 1'b0;
      digit_err_q <= 1'b0;
      case (mode_q)
        SET_CLK, SET_ALM, SET_TMR: begin
          pend_alm_q <= pend_alm_q | alm_rise;
          pend_tmr_q <= pend_tmr_q | tmr_rise;
          if (btn_rise) begin
            mode_q     <= nm;
            strb_q     <= strobes_of(nm);
            select_q   <= is_set(nm) ? 3'd5 : cur_sel;
            dec_pend_q <= 1'b0;
            idle_q     <= '0;
          end else if (!bus.edit_strobe && idle_q >= IDLE_LAST) begin
            mode_q     <= CLOCK;
            strb_q     <= strobes_of(CLOCK);
            select_q   <= cur_sel;
            dec_pend_q <= 1'b0;
            idle_q     <= '0;
          end else begin
            select_q <= cur_sel;
            idle_q   <= bus.edit_strobe ? '0 : idle_d;
            if (bus.edit_strobe && edit_ok) begin
              field_wr_q   <= 1'b1;
              field_data_q <= bus.loadin;
              dec_pend_q   <= 1'b1;
              if (cur_sel == 3'd5) begin
                if (mode_q == SET_CLK) h1_clk_q <= (bus.loadin == 4'd2);
                if (mode_q == SET_ALM) h1_alm_q <= (bus.loadin == 4'd2);
                if (mode_q == SET_TMR) h1_tmr_q <= (bus.loadin == 4'd2);
              end
            end else begin
              dec_pend_q  <= 1'b0;
              digit_err_q <= bus.edit_strobe;
            end
          end
        end

        ALERT: begin
          pend_alm_q <= pend_alm_q | alm_rise;
          pend_tmr_q <= pend_tmr_q | tmr_rise;
          // A button press here only acknowledges the alert. It does not advance the mode.
          if (bus.ack || btn_rise || hold_q >= HOLD_LAST) begin
            mode_q  <= saved_q;
            strb_q  <= strobes_of(saved_q);
            alert_q <= 1'b0;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_d;
          end
        end

        default: begin
          if (take_alm || take_tmr) begin
            mode_q      <= ALERT;
            saved_q     <= mode_q;
            strb_q      <= strobes_of(mode_q);
            alert_q     <= 1'b1;
            alert_src_q <= ~take_alm;
            hold_q      <= '0;
            if (take_alm) begin
              pend_alm_q <= 1'b0;
              pend_tmr_q <= take_tmr;
            end else begin
              pend_tmr_q <= 1'b0;
            end
          end else if (btn_rise) begin
            mode_q <= nm;
            strb_q <= strobes_of(nm);
            idle_q <= '0;
            if (is_set(nm)) begin
              select_q   <= 3'd5;
              dec_pend_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.mode       = mode_q;
  assign bus.load       = strb_q[4];
  assign bus.almin      = strb_q[3];
  assign bus.tmrin      = strb_q[2];
  assign bus.sw         = strb_q[1];
  assign bus.tmr        = strb_q[0];
  assign bus.select     = select_q;
  assign bus.field_wr   = field_wr_q;
  assign bus.field_data = field_data_q;
  assign bus.digit_err  = digit_err_q;
  assign bus.alert      = alert_q;
  assign bus.alert_src  = alert_src_q;

endmodule
